// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between the combinational instruction ROM and
// decode. Holds the PC, drives rom_addr, captures the returned word into a
// fetch register and hands it to decode over a valid/ready handshake.
// Handles branch redirect/flush, halt and start/resume.
//
// Handshake: if_valid/if_instr/if_pc form the producer side. A transfer
// happens on any cycle with if_valid && id_ready. While if_valid is high and
// id_ready is low, if_valid, if_instr and if_pc hold unchanged. A taken branch
// flushes the fetch register, so a word presented on a branch cycle is
// discarded even when id_ready is high.
//
// Optional build macro FETCH_PERF_CNT_EN adds a 16-bit saturating count of
// completed (non-flushed) transfers on output fetch_count.
module instr_fetch_unit #(
  parameter int N    = 10,
  parameter int IMMS = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt_req,
  input  logic            branch_taken,
  input  logic [IMMS-1:0] branch_target,
  output logic [IMMS-1:0] rom_addr,
  input  logic [N-1:0]    rom_instr,
  output logic            if_valid,
  output logic [N-1:0]    if_instr,
  output logic [IMMS-1:0] if_pc,
  input  logic            id_ready,
  output logic            halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [IMMS-1:0] PC_ONE = {{(IMMS-1){1'b0}}, 1'b1};

  state_e          state_q;
  logic [IMMS-1:0] pc_q;
  logic [IMMS-1:0] if_pc_q;
  logic [N-1:0]    if_instr_q;
  logic            if_valid_q;

  logic xfer;
  logic load;

  // Decode consumes the held word this cycle.
  assign xfer = if_valid_q && id_ready;
  // Fetch register is free: empty, or its word is leaving this cycle.
  assign load = !if_valid_q || xfer;

  // Fetch FSM: state, PC and the fetch register advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (branch_taken) begin
            // Redirect wins over load; a simultaneous halt still takes effect.
            pc_q       <= branch_target;
            if_valid_q <= 1'b0;
            if (halt_req) state_q <= S_HALT;
          end else if (halt_req) begin
            // No fetch on the halt cycle; a held word may still drain.
            state_q <= S_HALT;
            if (xfer) if_valid_q <= 1'b0;
          end else if (load) begin
            if_instr_q <= rom_instr;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_q + PC_ONE;
          end
        end
        S_HALT: begin
          if (branch_taken) begin
            pc_q       <= branch_target;
            if_valid_q <= 1'b0;
          end else if (xfer) begin
            if_valid_q <= 1'b0;
          end
          // halt_req beats start while halted.
          if (start && !halt_req) state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr = pc_q;
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign halted   = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q;
  logic        counted_xfer;

  // A branch in FETCH or HALT flushes the word, so that transfer is not counted.
  assign counted_xfer = xfer && !(branch_taken && (state_q != S_IDLE));

  // Saturating count of completed transfers; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else if (counted_xfer && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table for the documented sequences,
// a hand-written async-reset sequence, then randomized stimulus checked
// against a transaction-level reference model.
module tb_instr_fetch_unit;

  localparam int N    = 10;
  localparam int IMMS = 5;
  localparam int DEPTH = 1 << IMMS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start, halt_req, branch_taken, id_ready;
  logic [IMMS-1:0] branch_target;
  logic [IMMS-1:0] rom_addr;
  logic [N-1:0]    rom_instr;
  logic            if_valid;
  logic [N-1:0]    if_instr;
  logic [IMMS-1:0] if_pc;
  logic            halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]     fetch_count;
`endif

  logic [N-1:0] rom_mem [DEPTH];
  assign rom_instr = rom_mem[rom_addr];

  instr_fetch_unit #(.N(N), .IMMS(IMMS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .halt_req     (halt_req),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .rom_addr     (rom_addr),
    .rom_instr    (rom_instr),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .id_ready     (id_ready),
    .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_std_rom();
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = '0;
    rom_mem[0] = 10'h320;
    rom_mem[1] = 10'h2E2;
    rom_mem[2] = 10'h080;
    rom_mem[3] = 10'h1A7;
    rom_mem[4] = 10'h162;
    rom_mem[5] = 10'h080;
    rom_mem[6] = 10'h3C9;
    rom_mem[7] = 10'h055;
    rom_mem[9] = 10'h2C4;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
    branch_target = '0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic st, input logic hr, input logic br,
                       input logic [IMMS-1:0] tgt, input logic rdy);
    @(negedge clk);
    start = st; halt_req = hr; branch_taken = br; branch_target = tgt; id_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},  {31'd0, if_valid}, 32'd0);
    check({tag, ".instr"},  {22'd0, if_instr}, 32'd0);
    check({tag, ".pc"},     {27'd0, if_pc},    32'd0);
    check({tag, ".addr"},   {27'd0, rom_addr}, 32'd0);
    check({tag, ".halted"}, {31'd0, halted},   32'd0);
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".count"},  {16'd0, fetch_count}, 32'd0);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            st, hr, br;
    logic [IMMS-1:0] tgt;
    logic            rdy;
    logic            e_valid;
    logic [N-1:0]    e_instr;
    logic [IMMS-1:0] e_pc;
    logic [IMMS-1:0] e_addr;
    logic            e_halted;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic st, logic hr, logic br, logic [IMMS-1:0] tgt, logic rdy,
                              logic ev, logic [N-1:0] ei, logic [IMMS-1:0] ep,
                              logic [IMMS-1:0] ea, logic eh);
    vec_t v;
    v.st = st; v.hr = hr; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_addr = ea; v.e_halted = eh;
    return v;
  endfunction

  task automatic build_table();
    //            st hr br tgt rdy   ev instr    pc  addr halted
    vt.push_back(mk(0, 0, 1,  7, 0,   0, 10'h000,  0,  0, 0)); // branch in IDLE ignored
    vt.push_back(mk(1, 0, 0,  0, 1,   0, 10'h000,  0,  0, 0)); // start
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h320,  0,  1, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h2E2,  1,  2, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h080,  2,  3, 0));
    vt.push_back(mk(0, 0, 1,  9, 1,   0, 10'h000,  0,  9, 0)); // branch at if_pc=2 flushes
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h2C4,  9, 10, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h000, 10, 11, 0));
    vt.push_back(mk(0, 0, 1, 31, 1,   0, 10'h000,  0, 31, 0)); // branch to last word
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h000, 31,  0, 0)); // pc wraps
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h320,  0,  1, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h2E2,  1,  2, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h080,  2,  3, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h1A7,  3,  4, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h162,  4,  5, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,   1, 10'h162,  4,  5, 0)); // stall x3
    vt.push_back(mk(0, 0, 0,  0, 0,   1, 10'h162,  4,  5, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,   1, 10'h162,  4,  5, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h080,  5,  6, 0)); // release
    vt.push_back(mk(0, 0, 1,  3, 1,   0, 10'h000,  0,  3, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h1A7,  3,  4, 0));
    vt.push_back(mk(0, 1, 0,  0, 0,   1, 10'h1A7,  3,  4, 1)); // halt with word held
    vt.push_back(mk(0, 0, 0,  0, 0,   1, 10'h1A7,  3,  4, 1));
    vt.push_back(mk(0, 0, 0,  0, 1,   0, 10'h000,  0,  4, 1)); // drained
    vt.push_back(mk(1, 1, 0,  0, 1,   0, 10'h000,  0,  4, 1)); // halt beats start
    vt.push_back(mk(1, 0, 0,  0, 1,   0, 10'h000,  0,  4, 0)); // resume
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h162,  4,  5, 0)); // resumes at pc 4
    vt.push_back(mk(0, 1, 1,  6, 1,   0, 10'h000,  0,  6, 1)); // halt + branch
    vt.push_back(mk(0, 0, 0,  0, 1,   0, 10'h000,  0,  6, 1));
    vt.push_back(mk(1, 0, 0,  0, 1,   0, 10'h000,  0,  6, 0));
    vt.push_back(mk(0, 0, 0,  0, 1,   1, 10'h3C9,  6,  7, 0)); // resumes at pc 6
    vt.push_back(mk(1, 0, 0,  0, 1,   1, 10'h055,  7,  8, 0)); // start in FETCH ignored
    vt.push_back(mk(0, 0, 0,  0, 0,   1, 10'h055,  7,  8, 0)); // stall before async reset
  endtask

  // ---------------- reference model ----------------
  // Pipeline seen as: a mode, the next address to fetch, and a one-entry
  // holding slot toward decode.
  int unsigned  m_mode;   // 0 idle, 1 running, 2 halted
  int unsigned  m_next;
  bit           m_full;
  logic [N-1:0] m_word;
  int unsigned  m_from;
  int unsigned  m_count;

  task automatic model_reset();
    m_mode = 0; m_next = 0; m_full = 0; m_word = '0; m_from = 0; m_count = 0;
  endtask

  task automatic model_step(input bit st, input bit hr, input bit br,
                            input int unsigned tgt, input bit rdy);
    bit taken_by_decode;
    bit redirect;
    taken_by_decode = m_full && rdy;
    redirect = br && (m_mode != 0);
    if (taken_by_decode && !redirect && m_count < 65535) m_count = m_count + 1;
    if (m_mode == 0) begin
      if (st) m_mode = 1;
      return;
    end
    if (redirect) begin
      m_next = tgt;
      m_full = 0;
    end else if (m_mode == 1 && !hr && (!m_full || taken_by_decode)) begin
      m_word = rom_mem[m_next];
      m_from = m_next;
      m_full = 1;
      m_next = (m_next + 1) % DEPTH;
    end else if (taken_by_decode) begin
      m_full = 0;
    end
    if (m_mode == 1 && hr) m_mode = 2;
    else if (m_mode == 2 && st && !hr) m_mode = 1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"},  {31'd0, if_valid}, {31'd0, m_full});
    check({tag, ".addr"},   {27'd0, rom_addr}, m_next);
    check({tag, ".halted"}, {31'd0, halted},   {31'd0, (m_mode == 2)});
    if (m_full) begin
      check({tag, ".instr"}, {22'd0, if_instr}, {22'd0, m_word});
      check({tag, ".pc"},    {27'd0, if_pc},    m_from);
    end
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".count"}, {16'd0, fetch_count}, m_count);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    load_std_rom();
    build_table();
    do_reset();
    check_all_zero("reset");

    // directed table
    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].hr, vt[i].br, vt[i].tgt, vt[i].rdy);
      check($sformatf("vec%0d.valid", i),  {31'd0, if_valid}, {31'd0, vt[i].e_valid});
      check($sformatf("vec%0d.addr", i),   {27'd0, rom_addr}, {27'd0, vt[i].e_addr});
      check($sformatf("vec%0d.halted", i), {31'd0, halted},   {31'd0, vt[i].e_halted});
      if (vt[i].e_valid) begin
        check($sformatf("vec%0d.instr", i), {22'd0, if_instr}, {22'd0, vt[i].e_instr});
        check($sformatf("vec%0d.pc", i),    {27'd0, if_pc},    {27'd0, vt[i].e_pc});
      end
    end

    // async reset mid-stall, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    id_ready = 1'b1; start = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("post_rst.valid", {31'd0, if_valid}, 32'd0);
      check("post_rst.addr",  {27'd0, rom_addr}, 32'd0);
    end
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    check("post_rst_start.valid", {31'd0, if_valid}, 32'd1);
    check("post_rst_start.instr", {22'd0, if_instr}, 32'h320);
    check("post_rst_start.pc",    {27'd0, if_pc},    32'd0);

`ifdef FETCH_PERF_CNT_EN
    // five transfers then a flushed one
    do_reset();
    drive(1, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    check("perf.count5", {16'd0, fetch_count}, 32'd5);
    do_reset();
    check("perf.count_rst", {16'd0, fetch_count}, 32'd0);
`endif

    // randomized run against the reference model
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = N'($urandom);
    do_reset();
    model_reset();
    compare_model("rnd_rst");
    for (int c = 0; c < 3000; c++) begin
      bit st, hr, br, rdy;
      logic [IMMS-1:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      hr  = ($urandom_range(0, 15) == 0);
      br  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = IMMS'($urandom_range(0, DEPTH - 1));
      model_step(st, hr, br, int'(tgt), rdy);
      drive(st, hr, br, tgt, rdy);
      compare_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction ROM and downstream-feeding the decode stage.
- Holds the program counter and drives the ROM address; the ROM is combinational.
- Captures the returned instruction into a fetch register and presents it to decode with a valid/ready handshake.
- Handles branch redirect/flush, halt, and start/resume.

Parameters:
- N, 10, instruction width in bits; matches the ROM data width.
- IMMS, 5, PC/ROM address width in bits; address space is 2^IMMS words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle pulse; leaves IDLE or HALT and begins or resumes fetching.
- halt_req  input  1  stops further fetches.
- branch_taken  input  1  redirect request, sampled each cycle.
- branch_target  input  IMMS  redirect address.
- rom_addr  output  IMMS  address to the instruction ROM; always equals pc.
- rom_instr  input  N  combinational ROM data for rom_addr.
- if_valid  output  1  fetch register holds a valid instruction.
- if_instr  output  N  fetched instruction.
- if_pc  output  IMMS  address if_instr was fetched from.
- id_ready  input  1  decode accepts if_instr this cycle.
- halted  output  1  high while in HALT.

Behaviour:
- States: IDLE, FETCH, HALT.
- Reset (async, any time, including mid-fetch or mid-branch):
  - state=IDLE, pc=0, if_valid=0, if_instr=0, if_pc=0, halted=0.
  - An in-flight instruction is discarded.
- IDLE:
  - No fetch; if_valid=0.
  - start=1 -> FETCH; pc is unchanged (0 after reset).
- FETCH, load condition is load = !if_valid || (if_valid && id_ready). When load=1:
  - if_instr<=rom_instr, if_pc<=pc, if_valid<=1.
  - pc<=pc+1, modulo 2^IMMS; pc=2^IMMS-1 wraps to 0.
- FETCH, when load=0 (stall): pc, if_instr, if_pc and if_valid hold their values.
- Latency and throughput:
  - One cycle from pc to if_instr.
  - Sustained throughput of 1 instruction/cycle while id_ready=1.
- Handshake: a transfer occurs on a cycle with if_valid && id_ready. Decode may hold id_ready low indefinitely; the outputs must stay stable.
- Branch (branch_taken=1, in FETCH or HALT). Branch has highest priority after reset and overrides load:
  - pc<=branch_target.
  - if_valid<=0 (flush). The current if_instr is discarded even if id_ready=1 in the same cycle.
  - Next cycle fetches from branch_target, so the target instruction is valid 2 cycles after the branch cycle.
  - branch_target=current pc is legal and refetches.
- halt_req=1 in FETCH:
  - Go to HALT next cycle; halted=1.
  - No load occurs that cycle or after, and pc holds.
  - A held valid instruction stays valid until transferred, then if_valid=0.
- halt_req and branch_taken in the same cycle: pc<=branch_target, flush, then enter HALT.
- HALT:
  - start=1 -> FETCH, resuming at pc; halted=0 next cycle.
  - halt_req in HALT has no effect.
  - start and halt_req together in HALT: halt_req wins; stay in HALT.
- start in FETCH is ignored.
- branch_taken in IDLE is ignored.
- rom_instr is sampled only on load; X on rom_instr at other times must not propagate.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Add output fetch_count, 16 bits.
  - Increments by 1 on each completed transfer (if_valid && id_ready, not flushed by a simultaneous branch).
  - Saturates at 16'hFFFF.
  - Cleared by reset only.
- When undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then start, id_ready=1 with the standard ROM image:
  - if_instr sequence is 10'h320 (pc0), 10'h2E2 (pc1), 10'h080 (pc2), one per cycle, with if_pc 0,1,2.
  - rom_addr leads if_pc by 1.
- Stall: hold id_ready=0 for 3 cycles while if_pc=4 (if_instr 10'h162):
  - Outputs and rom_addr=5 stay constant.
  - Releasing id_ready delivers pc5 (10'h080) next cycle.
- Branch: branch_taken=1, branch_target=9 while if_pc=2 and id_ready=1:
  - if_valid=0 next cycle.
  - Cycle after that: if_pc=9, if_instr=10'h2C4; then pc 10 delivers 10'h000 (default ROM word).
- Wrap: branch to 31, run:
  - if_pc sequence 31 then 0, with if_instr 10'h000 then 10'h320.
- Halt/resume: halt_req at if_pc=3 with id_ready=0:
  - halted=1, if_valid stays 1 until id_ready=1, then 0.
  - start resumes at pc=4.
  - Also check: halt_req together with branch_target=6 resumes at pc 6.
- Async reset asserted mid-stall (not on a clock edge):
  - All outputs are 0 immediately.
  - After deassert, no fetch occurs until start.
  - With FETCH_PERF_CNT_EN: fetch_count after 5 transfers plus a flushed one reads 5; after reset it reads 0.
